// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int FRAME_LEN_BYTES = 2;
    localparam int WORD_BYTES      = 4;

    // States in which the loader is consuming frame bytes.
    function automatic logic is_busy(input state_t s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs little-endian bytes into 32-bit words; word_valid pulses the cycle after the 4th byte.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] low;

    assign last_byte = (idx == 2'(WORD_BYTES - 1));

    // Earlier bytes shift down so the first byte of a word ends up in bits [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            low        <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx <= '0;
                low <= '0;
            end else if (byte_valid) begin
                idx <= idx + 2'd1;
                low <= {byte_data, low[23:8]};
                if (last_byte) begin
                    word       <= {byte_data, low};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into word-addressed instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output state_t            state_dbg
);

    localparam int LEN_W = 8 * FRAME_LEN_BYTES;

    state_t            state, next_state;
    logic              transfer;
    logic              start_acc;
    logic [7:0]        len_lo;
    logic [LEN_W-1:0]  frame_len;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        csum;
    logic              last_byte;

    // Handshake: a byte moves only in a cycle where in_valid and in_ready are both 1;
    // in_ready is registered and depends on nothing combinational from the sender.
    assign transfer  = in_valid & in_ready;
    assign start_acc = start & ~is_busy(state);
    assign frame_len = {in_data, len_lo};
    assign state_dbg = state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN0;
            S_LEN0:  if (transfer) next_state = S_LEN1;
            S_LEN1: begin
                if (transfer) begin
                    if (frame_len > LEN_W'(DEPTH))  next_state = S_ERR;
                    else if (frame_len == '0)       next_state = S_CHECK;
                    else                            next_state = S_DATA;
                end
            end
            S_DATA:  if (transfer && last_byte && (word_addr == last_addr)) next_state = S_CHECK;
            S_CHECK: if (transfer) next_state = (in_data == csum) ? S_DONE : S_ERR;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wr_addr   <= '0;
            len_lo    <= '0;
            last_addr <= '0;
            word_addr <= '0;
            csum      <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= is_busy(next_state);
            core_hold <= (next_state != S_IDLE) && (next_state != S_DONE);
            done      <= (next_state == S_DONE);
            error     <= (next_state == S_ERR);

            if (start_acc) begin
                csum      <= '0;
                word_addr <= '0;
            end else if (transfer && (state != S_CHECK)) begin
                csum <= csum ^ in_data;
            end

            if (transfer && (state == S_LEN0)) len_lo <= in_data;
            if (transfer && (state == S_LEN1)) last_addr <= ADDR_W'(frame_len - LEN_W'(1));

            // The address is captured alongside the packed word so both appear with wr_en.
            if (transfer && (state == S_DATA) && last_byte) begin
                wr_addr   <= word_addr;
                word_addr <= word_addr + ADDR_W'(1);
            end
        end
    end

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_acc),
        .byte_valid (transfer && (state == S_DATA)),
        .byte_data  (in_data),
        .last_byte  (last_byte),
        .word_valid (wr_en),
        .word       (wr_data)
    );

endmodule
